// File: rtl/multu_hilo_unit.sv
// Iterative unsigned shift-add multiplier with architectural HI/LO registers.
// One multiplier bit per cycle; HI/LO commit atomically on the last RUN edge.
//   state | meaning
//   IDLE  | waiting for MULTU; HI/LO hold the last committed product
//   RUN   | shift-add in progress, busy asserted
module multu_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
        // The carry out of the upper-half add becomes the new MSB after the shift.
        acc_step = {sum, acc_q[WIDTH-1:1]};

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_step;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_d    = acc_step[2*WIDTH-1:WIDTH];
                        lo_d    = acc_step[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign stall = busy & (start | rd_hilo);

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: latency, atomic commit, stall, flush and async reset.
module tb_multu_hilo_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        rd_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    multu_hilo_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .rd_hilo (rd_hilo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Starts a multiply in the current cycle and checks the whole 33-cycle window.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int nb = 0;
        int nd = 0;
        int moved = 0;
        logic [31:0] ph = hi;
        logic [31:0] pl = lo;
        start = 1'b1; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (hi !== ph || lo !== pl) moved++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
        chk({tag, "_early_done"}, 64'(nd), 64'd0);
        chk({tag, "_hilo_held"}, 64'(moved), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        int ns;
        int nb;
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; flush = 1'b0; rd_hilo = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_mult("m3x5", 32'd3, 32'd5, 32'h0, 32'h0000000F);

        // flush in RUN cycle 10
        start = 1'b1; op_a = 32'd7; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("fl_busy_c10", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy_after", 64'(busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("fl_no_done", 64'(nd), 64'd0);
        chk("fl_hi", 64'(hi), 64'd0);
        chk("fl_lo", 64'(lo), 64'd15);

        // flush together with start in IDLE
        start = 1'b1; flush = 1'b1; op_a = 32'd4; op_b = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("fs_busy", 64'(busy), 64'd0);

        run_mult("mmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        // flush on the final RUN edge: no commit
        start = 1'b1; op_a = 32'd10; op_b = 32'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        chk("ff_busy_c32", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("ff_done", 64'(done), 64'd0);
        chk("ff_busy", 64'(busy), 64'd0);
        chk("ff_lo", 64'(lo), 64'h00000001);
        chk("ff_hi", 64'(hi), 64'hFFFFFFFE);

        // asynchronous reset in RUN cycle 20
        start = 1'b1; op_a = 32'd7; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_hi", 64'(hi), 64'd0);
        chk("ar_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("ar_no_done", 64'(nd), 64'd0);
        run_mult("m2x2", 32'd2, 32'd2, 32'h0, 32'd4);

        // dependent MFHI/MFLO right behind MULTU
        start = 1'b1; op_a = 32'h00010000; op_b = 32'h00010000;
        @(negedge clk);
        start = 1'b0; rd_hilo = 1'b1;
        ns = 0;
        for (int i = 0; i < 32; i++) begin
            if (stall) ns++;
            @(negedge clk);
        end
        chk("rd_stall_cycles", 64'(ns), 64'd32);
        chk("rd_stall_done", 64'(stall), 64'd0);
        chk("rd_done", 64'(done), 64'd1);
        chk("rd_hi", 64'(hi), 64'h1);
        chk("rd_lo", 64'(lo), 64'h0);
        rd_hilo = 1'b0;
        @(negedge clk);
        chk("indep_stall", 64'(stall), 64'd0);

        // back-to-back MULTU with start held high
        start = 1'b1; op_a = 32'd6; op_b = 32'd7;
        @(negedge clk);
        op_a = 32'd8; op_b = 32'd8;
        ns = 0;
        for (int i = 0; i < 32; i++) begin
            if (stall) ns++;
            @(negedge clk);
        end
        chk("bb_stall_cycles", 64'(ns), 64'd32);
        chk("bb_done1", 64'(done), 64'd1);
        chk("bb_lo1", 64'(lo), 64'd42);
        chk("bb_stall_done", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy) nb++;
            @(negedge clk);
        end
        chk("bb_busy2", 64'(nb), 64'd32);
        chk("bb_done2", 64'(done), 64'd1);
        chk("bb_lo2", 64'(lo), 64'd64);
        chk("bb_hi2", 64'(hi), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Iterative unsigned multiplier with architectural HI/LO registers for the pipelined CPU's EX stage.
- Executes MULTU and supplies the HI/LO values read by MFHI/MFLO.
- Drives a stall request to the hazard logic while a multiply is in flight.
- Sits beside the ALU and feeds the EX/MEM write-back path (rfile_wd source for MFHI/MFLO).

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits split into HI (upper) and LO (lower).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  MULTU in EX stage; request to begin a multiply.
- op_a  input  WIDTH  multiplicand (rs value).
- op_b  input  WIDTH  multiplier (rt value).
- flush  input  1  squash the in-flight multiply (branch/jump kill).
- rd_hilo  input  1  MFHI or MFLO currently in EX stage.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse marking the cycle in which HI/LO take the new product.
- stall  output  1  hazard request: hold IF/ID/EX.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, internal accumulator/count=0.
  - Reset asserted mid-RUN aborts immediately; HI/LO return to 0.
- States: IDLE, RUN.
- IDLE:
  - On a clock edge with start=1 and flush=0: latch op_a and op_b, clear the 2*WIDTH accumulator, count=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Shift-add, one multiplier bit per cycle, LSB first. If the current multiplier bit is 1, add the multiplicand into the upper half of the accumulator. The carry goes into a WIDTH+1-bit sum, then the accumulator shifts right by 1.
  - count increments each cycle.
  - On the WIDTH-th RUN edge: hi<=acc[2W-1:W], lo<=acc[W-1:0], done<=1, go to IDLE.
- Latency is fixed, independent of operand values (zero operands still take WIDTH cycles).
  - start high in cycle 0 → busy=1 in cycles 1..WIDTH.
  - done=1 and new hi/lo visible in cycle WIDTH+1.
- Atomic commit: hi/lo hold their previous values throughout RUN and update only at the final edge.
- busy = (state==RUN), registered.
- done: registered, exactly one cycle per completed multiply; never asserted after a flushed or reset multiply.
- stall (combinational) = busy & (start | rd_hilo).
  - A dependent MFHI/MFLO, or a second MULTU, is held until done.
  - Independent instructions are not stalled.
- start while busy: ignored by the datapath; stall holds the instruction in EX, and it is accepted on the first IDLE edge.
- start in the done cycle: accepted (state is IDLE).
- flush:
  - During RUN: next edge returns to IDLE, busy=0, no done, hi/lo unchanged.
  - flush and start in the same IDLE cycle: flush wins, nothing starts.
  - flush on the final RUN edge: flush wins, no commit.
- All arithmetic is unsigned modulo 2^(2*WIDTH); no overflow is possible.

Test Plan:
- Reset, then start with op_a=3, op_b=5 → busy high 32 cycles; then hi=0x00000000, lo=0x0000000F, done pulses for exactly 1 cycle.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 in cycle 33 after start.
- MULTU 0x00010000×0x00010000, followed by rd_hilo=1 the next cycle:
  - stall=1 for all 32 busy cycles, stall=0 in the done cycle.
  - Result: hi=0x00000001, lo=0x00000000.
- Prior result hi=0, lo=15; start 7×9, assert flush in RUN cycle 10 → busy=0 on the next edge, done never pulses, hi=0, lo=15 retained.
- Assert reset asynchronously (between edges) in RUN cycle 20 → hi=lo=0, busy=0 immediately; a new start 2×2 afterwards → lo=4 after 32 cycles.
- Hold start high continuously with 6×7, then 8×8 presented back-to-back:
  - The second start is held off by stall and begins in the done cycle of the first (lo=42).
  - Then lo=64, 33 cycles later.
